// File: rtl/mux_scan_ctrl.sv
`timescale 1ns/1ps
// mux_scan_ctrl: steps a keyed selector, lets each key settle, samples it, and hands a full frame downstream over valid/ready.
// Optional build macro MUX_SCAN_DEDUP_EN suppresses frames identical to the last accepted one.
module mux_scan_ctrl #(
    parameter int NR_KEY     = 4,
    parameter int KEY_LEN    = 2,
    parameter int DATA_LEN   = 2,
    parameter int SETTLE_CYC = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       continuous,
    output logic [KEY_LEN-1:0]         sel,
    input  logic [DATA_LEN-1:0]        mux_in,
    output logic                       frame_valid,
    input  logic                       frame_ready,
    output logic [NR_KEY*DATA_LEN-1:0] frame_data,
    output logic                       busy
);
    localparam int                 FRAME_W  = NR_KEY * DATA_LEN;
    localparam logic [KEY_LEN-1:0] LAST_KEY = KEY_LEN'(NR_KEY - 1);
    localparam logic [7:0]         CNT_LAST = 8'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_HOLD
    } state_e;

    state_e               state_q, state_d;
    logic [KEY_LEN-1:0]   sel_q, sel_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [FRAME_W-1:0]   shadow_q, shadow_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 valid_q, valid_d;
    logic [FRAME_W-1:0]   sample_frame;
    logic                 accept;
    logic                 dup_hit;

    assign accept = (state_q == S_HOLD) && valid_q && frame_ready;

    // Shadow buffer as it will look once the current key's sample is written.
    always_comb begin
        sample_frame = shadow_q;
        sample_frame[DATA_LEN*int'(sel_q) +: DATA_LEN] = mux_in;
    end

`ifdef MUX_SCAN_DEDUP_EN
    logic [FRAME_W-1:0] last_q, last_d;
    logic               delivered_q, delivered_d;

    always_comb begin
        last_d      = last_q;
        delivered_d = delivered_q;
        if (accept) begin
            last_d      = frame_q;
            delivered_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q      <= '0;
            delivered_q <= 1'b0;
        end else begin
            last_q      <= last_d;
            delivered_q <= delivered_d;
        end
    end

    assign dup_hit = delivered_q && (sample_frame == last_q);
`else
    assign dup_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        frame_d  = frame_q;
        valid_d  = valid_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == CNT_LAST) state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                shadow_d = sample_frame;
                if (sel_q != LAST_KEY) begin
                    sel_d   = sel_q + KEY_LEN'(1);
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else if (dup_hit) begin
                    // Repeat of the last accepted frame: behave as if it was just handed over.
                    if (continuous) begin
                        sel_d   = '0;
                        cnt_d   = '0;
                        state_d = S_SETTLE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    frame_d = sample_frame;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (accept) begin
                    valid_d = 1'b0;
                    if (continuous) begin
                        sel_d   = '0;
                        cnt_d   = '0;
                        state_d = S_SETTLE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the sample buffers are cleared on reset too, so no stale data can ever reach frame_data.
            state_q  <= S_IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            frame_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            frame_q  <= frame_d;
            valid_q  <= valid_d;
        end
    end

    assign sel         = sel_q;
    assign frame_valid = valid_q;
    assign frame_data  = frame_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
`timescale 1ns/1ps
// Directed bench for mux_scan_ctrl with a behavioural 4-way selector on sel/mux_in.
// Dedup steps only run when MUX_SCAN_DEDUP_EN is defined.
module tb_mux_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       continuous = 1'b0;
    logic       frame_ready = 1'b0;
    logic [1:0] sel;
    logic [1:0] mux_in;
    logic       frame_valid;
    logic [7:0] frame_data;
    logic       busy;
    logic [1:0] x0 = 2'b01, x1 = 2'b10, x2 = 2'b11, x3 = 2'b00;

    int n_assert = 0;
    int n_fail   = 0;
    int pulses;
    int waited;

    mux_scan_ctrl #(
        .NR_KEY(4), .KEY_LEN(2), .DATA_LEN(2), .SETTLE_CYC(5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .sel        (sel),
        .mux_in     (mux_in),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .frame_data (frame_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    assign mux_in = (sel == 2'd0) ? x0 :
                    (sel == 2'd1) ? x1 :
                    (sel == 2'd2) ? x2 : x3;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic count_pulses(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (frame_valid === 1'b1) cnt++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            start       = 1'($urandom);
            continuous  = 1'($urandom);
            frame_ready = 1'($urandom);
            x0 = 2'($urandom); x1 = 2'($urandom); x2 = 2'($urandom); x3 = 2'($urandom);
            tick();
        end
        check("rst_sel",   32'(sel),         32'd0);
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_data",  32'(frame_data),  32'h00);
        check("rst_busy",  32'(busy),        32'd0);

        start = 1'b0; continuous = 1'b0; frame_ready = 1'b0;
        x0 = 2'b01; x1 = 2'b10; x2 = 2'b11; x3 = 2'b00;
        rst = 1'b1;
        repeat (50) tick();
        check("idle_sel",   32'(sel),         32'd0);
        check("idle_valid", 32'(frame_valid), 32'd0);
        check("idle_data",  32'(frame_data),  32'h00);
        check("idle_busy",  32'(busy),        32'd0);

        // Single scan, key k held for edges 6k..6k+5, valid on edge 24
        frame_ready = 1'b1;
        pulse_start();
        for (int e = 1; e <= 24; e++) begin
            tick();
            check("scan_sel",   32'(sel),         (e / 6 > 3) ? 32'd3 : 32'(e / 6));
            check("scan_valid", 32'(frame_valid), 32'(e == 24));
        end
        check("scan_data", 32'(frame_data), 32'h39);
        check("scan_busy", 32'(busy),       32'd1);
        tick();
        check("scan_valid_drop", 32'(frame_valid), 32'd0);
        check("scan_busy_drop",  32'(busy),        32'd0);
        check("scan_sel_hold",   32'(sel),         32'd3);
        check("scan_data_keep",  32'(frame_data),  32'h39);

        // Backpressure
        frame_ready = 1'b0;
        pulse_start();
        repeat (24) tick();
        check("bp_valid_rise", 32'(frame_valid), 32'd1);
        repeat (10) tick();
        check("bp_valid_held", 32'(frame_valid), 32'd1);
        check("bp_data_held",  32'(frame_data),  32'h39);
        check("bp_busy_held",  32'(busy),        32'd1);
        frame_ready = 1'b1;
        tick();
        check("bp_valid_drop", 32'(frame_valid), 32'd0);
        check("bp_idle",       32'(busy),        32'd0);

        // Continuous: x1 changes during key-3 settle of the first scan
        continuous = 1'b1;
        pulse_start();
        for (int e = 1; e <= 24; e++) begin
            tick();
            if (e == 19) x1 = 2'b01;
        end
        check("cont_valid1", 32'(frame_valid), 32'd1);
        check("cont_data1",  32'(frame_data),  32'h39);
        tick();
        check("cont_restart_sel",   32'(sel),         32'd0);
        check("cont_restart_busy",  32'(busy),        32'd1);
        check("cont_restart_valid", 32'(frame_valid), 32'd0);
        repeat (23) tick();
        check("cont_valid2_early", 32'(frame_valid), 32'd0);
        tick();
        check("cont_valid2", 32'(frame_valid), 32'd1);
        check("cont_data2",  32'(frame_data),  32'h35);
        continuous = 1'b0;
        tick();
        check("cont_stop_valid", 32'(frame_valid), 32'd0);
        check("cont_stop_busy",  32'(busy),        32'd0);

        // Reset mid-scan takes effect before the next edge
        x1 = 2'b10;
        pulse_start();
        repeat (10) tick();
        check("mid_sel_before", 32'(sel),  32'd1);
        check("mid_busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_sel",   32'(sel),         32'd0);
        check("mid_rst_busy",  32'(busy),        32'd0);
        check("mid_rst_valid", 32'(frame_valid), 32'd0);
        check("mid_rst_data",  32'(frame_data),  32'h00);
        tick();
        rst = 1'b1;
        pulse_start();
        repeat (24) tick();
        check("post_rst_valid", 32'(frame_valid), 32'd1);
        check("post_rst_data",  32'(frame_data),  32'h39);
        tick();
        check("post_rst_idle", 32'(busy), 32'd0);

        // Start pulses while busy are ignored; frame 01_11_10_01
        x3 = 2'b01;
        pulse_start();
        pulses = 0;
        for (int e = 1; e <= 40; e++) begin
            start = (e == 7 || e == 15);
            tick();
            if (frame_valid === 1'b1) pulses++;
        end
        start = 1'b0;
        check("busy_start_frames", 32'(pulses),     32'd1);
        check("busy_start_data",   32'(frame_data), 32'h79);
        check("busy_start_idle",   32'(busy),       32'd0);

`ifdef MUX_SCAN_DEDUP_EN
        // Static data in continuous mode delivers once; a data change delivers once more
        x0 = 2'b10;
        continuous = 1'b1;
        pulse_start();
        count_pulses(100, pulses);
        check("dedup_static_frames", 32'(pulses),     32'd1);
        check("dedup_static_data",   32'(frame_data), 32'h7A);
        x2 = 2'b00;
        count_pulses(60, pulses);
        check("dedup_change_frames", 32'(pulses),     32'd1);
        check("dedup_change_data",   32'(frame_data), 32'h4A);
        continuous = 1'b0;
        waited = 0;
        while (busy === 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        check("dedup_stop_busy", 32'(busy), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
